bank_register_mp: RTL and testbench
===================================

Name: bank_register_mp

Overview:
Parametrised successor to the decode-stage register bank. Provides N_READ synchronous read ports and one write port with write-through bypass, and a reset that clears the whole bank. Adds a debug-unit dump sequencer that streams every register out over a valid/ready handshake. Sits in the DECODE stage: WB drives the write port, the ID/EX latch consumes the read ports, and the Debug Unit consumes the dump stream.

Parameters:
NB_DATA, 32, register width in bits
NB_ADDR, 5, register address width
BANK_DEPTH, 32, number of registers; must be ≤ 2**NB_ADDR
N_READ, 2, number of read ports (≥1)

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  pipeline enable from Debug Unit; gates writes and read-port updates
i_reg_write  in  1  RegWrite from WB
i_write_reg  in  NB_ADDR  write address
i_write_data  in  NB_DATA  write data
i_read_regs  in  N_READ*NB_ADDR  packed read addresses, port k at bits [k*NB_ADDR +: NB_ADDR]
o_read_data  out  N_READ*NB_DATA  packed registered read data, same packing
i_dump_start  in  1  single-cycle request to start a full-bank dump
i_dump_ready  in  1  Debug Unit accepts current dump beat
o_dump_valid  out  1  dump beat valid
o_dump_addr  out  NB_ADDR  register index of current beat
o_dump_data  out  NB_DATA  register contents of current beat
o_dump_last  out  1  high with the beat for index BANK_DEPTH-1
o_dump_busy  out  1  dump sequencer not IDLE

Behaviour:
- Reset (sync): all BANK_DEPTH registers ← 0; o_read_data ← 0; FSM ← IDLE; dump counter ← 0; o_dump_valid/last/busy = 0. Reset mid-dump aborts: busy and valid are low from the cycle after the reset edge.
- Write: on an edge with i_enable=1, i_reg_write=1 and FSM=IDLE, registers[i_write_reg] ← i_write_data. Writes with i_write_reg ≥ BANK_DEPTH are dropped.
- Read ports: 1-cycle latency. On an edge with i_enable=1, each port k loads registers[addr_k]. If i_reg_write=1, the write is accepted, and addr_k == i_write_reg, port k loads i_write_data instead (bypass, same cycle). Bypass applies independently to every port, including several ports with the same address. Out-of-range read address returns 0.
- i_enable=0: no writes; o_read_data holds its value.
- Dump FSM states are IDLE and STREAM.
  - IDLE→STREAM on i_dump_start=1. Counter ← 0.
  - In STREAM: o_dump_busy=1, o_dump_valid=1, o_dump_addr=counter, o_dump_data=registers[counter] (combinational from the array; stable because writes are blocked).
  - On valid&&ready: counter+1. If o_dump_last, go to IDLE on the next edge, with busy and valid low that cycle.
  - o_dump_valid is held and beat contents stay unchanged while i_dump_ready=0. No timeout.
  - i_dump_start while busy is ignored. Start and a write on the same edge: the write is accepted (FSM still IDLE), so the dump sees the new value.
- While busy: i_reg_write is ignored (write is lost, not queued); read ports still update if i_enable=1, without bypass.
- Counter is NB_ADDR bits and never wraps past BANK_DEPTH-1.

Optional Feature:
REG_ZERO_HARDWIRE_EN. When defined, register 0 is read-only zero. Writes to address 0 are dropped, read ports and dump return 0 for index 0, and there is no bypass for address 0. When undefined, register 0 is an ordinary register.

Test Plan:
- Reset then read: assert i_reset 1 cycle; i_enable=1, read addrs {3,7} → o_read_data = {0,0} one cycle later.
- Write/read: write r5=0xDEADBEEF; next cycle read r5 on port 0 → 0xDEADBEEF after 1 cycle. i_enable=0 with r5 write of 0x1 → r5 unchanged, output held.
- Bypass: same cycle write r9=0x1234 and read r9 on both ports → both ports show 0x1234 next cycle; port 1 reading r2 shows old r2.
- Dump with backpressure: preload rK=K+0x100. Pulse start, ready toggling 1,0,1,… → 32 beats addr 0..31, data 0x100..0x11F; beat held while ready=0; last only on addr 31; busy drops the cycle after the last handshake. A write attempted mid-dump is not applied.
- Reset mid-dump: assert reset after beat 10 → valid and busy low next cycle; all registers 0; a new start begins at addr 0.
- Macro REG_ZERO_HARDWIRE_EN defined: write r0=0xFFFF_FFFF with same-cycle read r0 → 0; dump beat 0 data = 0. Undefined: same stimulus → 0xFFFF_FFFF.

Source files
------------

// File: rtl/bank_register_mp.sv
// Decode-stage register bank: N_READ registered read ports with write-through bypass,
// one write port, and a valid/ready dump sequencer. Optional macro: REG_ZERO_HARDWIRE_EN.
module bank_register_mp #(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDR    = 5,
  parameter int BANK_DEPTH = 32,
  parameter int N_READ     = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_reg_write,
  input  logic [NB_ADDR-1:0]        i_write_reg,
  input  logic [NB_DATA-1:0]        i_write_data,
  input  logic [N_READ*NB_ADDR-1:0] i_read_regs,
  output logic [N_READ*NB_DATA-1:0] o_read_data,
  input  logic                      i_dump_start,
  input  logic                      i_dump_ready,
  output logic                      o_dump_valid,
  output logic [NB_ADDR-1:0]        o_dump_addr,
  output logic [NB_DATA-1:0]        o_dump_data,
  output logic                      o_dump_last,
  output logic                      o_dump_busy
);

`ifdef REG_ZERO_HARDWIRE_EN
  localparam bit ZERO_HW = 1'b1;
`else
  localparam bit ZERO_HW = 1'b0;
`endif

  localparam logic [NB_ADDR:0]   DEPTH    = (NB_ADDR+1)'(BANK_DEPTH);
  localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(BANK_DEPTH-1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state, state_next;
  logic [NB_ADDR-1:0]   dump_cnt, dump_cnt_next;
  logic [NB_DATA-1:0]   registers [BANK_DEPTH];
  logic [NB_DATA-1:0]   read_next [N_READ];
  logic [N_READ*NB_DATA-1:0] read_q;
  logic                 write_accept;

  function automatic logic addr_readable(input logic [NB_ADDR-1:0] a);
    return ({1'b0, a} < DEPTH) && !(ZERO_HW && (a == '0));
  endfunction

  // Writes are blocked during a dump so the streamed snapshot stays coherent.
  always_comb begin
    write_accept = i_enable && i_reg_write && (state == IDLE) && addr_readable(i_write_reg);
  end

  always_comb begin
    for (int k = 0; k < N_READ; k++) begin
      logic [NB_ADDR-1:0] read_addr;
      read_addr    = i_read_regs[k*NB_ADDR +: NB_ADDR];
      read_next[k] = '0;
      if (addr_readable(read_addr))
        read_next[k] = registers[read_addr];
      if (write_accept && (read_addr == i_write_reg))
        read_next[k] = i_write_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < BANK_DEPTH; i++)
        registers[i] <= '0;
    end else if (write_accept) begin
      registers[i_write_reg] <= i_write_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      read_q <= '0;
    end else if (i_enable) begin
      for (int k = 0; k < N_READ; k++)
        read_q[k*NB_DATA +: NB_DATA] <= read_next[k];
    end
  end

  assign o_read_data = read_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= IDLE;
      dump_cnt <= '0;
    end else begin
      state    <= state_next;
      dump_cnt <= dump_cnt_next;
    end
  end

  // Counter parks at zero after the final beat so it never runs past the last index.
  always_comb begin
    state_next    = state;
    dump_cnt_next = dump_cnt;
    o_dump_valid  = 1'b0;
    o_dump_busy   = 1'b0;
    o_dump_last   = 1'b0;
    case (state)
      IDLE: begin
        if (i_dump_start) begin
          state_next    = STREAM;
          dump_cnt_next = '0;
        end
      end
      STREAM: begin
        o_dump_valid = 1'b1;
        o_dump_busy  = 1'b1;
        o_dump_last  = (dump_cnt == LAST_IDX);
        if (i_dump_ready) begin
          if (dump_cnt == LAST_IDX) begin
            state_next    = IDLE;
            dump_cnt_next = '0;
          end else begin
            dump_cnt_next = dump_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_dump_data = '0;
    if (addr_readable(dump_cnt))
      o_dump_data = registers[dump_cnt];
  end

  assign o_dump_addr = dump_cnt;

endmodule

// File: tb/tb_bank_register_mp.sv
// Randomized + directed bench for bank_register_mp against a queue/array reference model.
module tb_bank_register_mp;

  localparam int NB_DATA    = 32;
  localparam int NB_ADDR    = 5;
  localparam int BANK_DEPTH = 32;
  localparam int N_READ     = 2;

`ifdef REG_ZERO_HARDWIRE_EN
  localparam bit          HW     = 1'b1;
  localparam logic [31:0] R0_EXP = 32'h0;
`else
  localparam bit          HW     = 1'b0;
  localparam logic [31:0] R0_EXP = 32'hFFFF_FFFF;
`endif

  logic                      i_clock = 1'b0;
  logic                      i_reset = 1'b0;
  logic                      i_enable = 1'b0;
  logic                      i_reg_write = 1'b0;
  logic [NB_ADDR-1:0]        i_write_reg = '0;
  logic [NB_DATA-1:0]        i_write_data = '0;
  logic [N_READ*NB_ADDR-1:0] i_read_regs = '0;
  logic [N_READ*NB_DATA-1:0] o_read_data;
  logic                      i_dump_start = 1'b0;
  logic                      i_dump_ready = 1'b0;
  logic                      o_dump_valid;
  logic [NB_ADDR-1:0]        o_dump_addr;
  logic [NB_DATA-1:0]        o_dump_data;
  logic                      o_dump_last;
  logic                      o_dump_busy;

  bank_register_mp #(
    .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .BANK_DEPTH(BANK_DEPTH), .N_READ(N_READ)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable),
    .i_reg_write(i_reg_write), .i_write_reg(i_write_reg), .i_write_data(i_write_data),
    .i_read_regs(i_read_regs), .o_read_data(o_read_data),
    .i_dump_start(i_dump_start), .i_dump_ready(i_dump_ready),
    .o_dump_valid(o_dump_valid), .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data),
    .o_dump_last(o_dump_last), .o_dump_busy(o_dump_busy)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [NB_ADDR-1:0] addr;
    logic [NB_DATA-1:0] data;
  } beat_t;

  logic [NB_DATA-1:0] m_regs [BANK_DEPTH];
  logic [NB_DATA-1:0] m_rd   [N_READ];
  beat_t              m_dump [$];
  int n_checks = 0;
  int n_pass   = 0;
  int dut_beats;

  function automatic logic [NB_DATA-1:0] model_read(input int a);
    if (a >= BANK_DEPTH || (HW && a == 0)) return '0;
    return m_regs[a];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  function automatic logic [NB_DATA-1:0] port_data(input int k);
    return o_read_data[k*NB_DATA +: NB_DATA];
  endfunction

  // One clock: advance the model from the current inputs, clock the DUT, compare.
  task automatic applyStimulus();
    bit busy_pre;
    bit wr;
    int a;
    busy_pre = (m_dump.size() != 0);
    if (busy_pre && i_dump_ready && o_dump_valid) dut_beats++;
    if (i_reset) begin
      for (int i = 0; i < BANK_DEPTH; i++) m_regs[i] = '0;
      for (int k = 0; k < N_READ; k++) m_rd[k] = '0;
      m_dump.delete();
    end else begin
      wr = i_enable && i_reg_write && !busy_pre && (int'(i_write_reg) < BANK_DEPTH)
           && !(HW && i_write_reg == '0);
      if (i_enable) begin
        for (int k = 0; k < N_READ; k++) begin
          a = int'(i_read_regs[k*NB_ADDR +: NB_ADDR]);
          m_rd[k] = (wr && a == int'(i_write_reg)) ? i_write_data : model_read(a);
        end
      end
      if (wr) m_regs[i_write_reg] = i_write_data;
      if (busy_pre) begin
        if (i_dump_ready) void'(m_dump.pop_front());
      end else if (i_dump_start) begin
        for (int i = 0; i < BANK_DEPTH; i++) begin
          beat_t b;
          b.addr = NB_ADDR'(i);
          b.data = model_read(i);
          m_dump.push_back(b);
        end
      end
    end
    @(posedge i_clock);
    #1;
    for (int k = 0; k < N_READ; k++)
      checkOutput($sformatf("read_data[%0d]", k), port_data(k), m_rd[k]);
    checkOutput("dump_valid", o_dump_valid, m_dump.size() != 0);
    checkOutput("dump_busy", o_dump_busy, m_dump.size() != 0);
    if (m_dump.size() != 0) begin
      checkOutput("dump_addr", o_dump_addr, m_dump[0].addr);
      checkOutput("dump_data", o_dump_data, m_dump[0].data);
      checkOutput("dump_last", o_dump_last, m_dump.size() == 1);
    end else begin
      checkOutput("dump_last_idle", o_dump_last, 0);
    end
  endtask

  function automatic logic [N_READ*NB_ADDR-1:0] pack_addr(input int a0, input int a1);
    return {NB_ADDR'(a1), NB_ADDR'(a0)};
  endfunction

  initial begin
    int cyc;

    // Reset then read r3/r7.
    i_reset = 1'b1;
    applyStimulus();
    i_reset = 1'b0;
    i_enable = 1'b1;
    i_read_regs = pack_addr(3, 7);
    applyStimulus();
    checkOutput("reset_read_p0", port_data(0), 0);
    checkOutput("reset_read_p1", port_data(1), 0);

    // Write r5, read back, then a disabled write must not land.
    i_reg_write = 1'b1; i_write_reg = 5; i_write_data = 32'hDEAD_BEEF;
    applyStimulus();
    i_reg_write = 1'b0; i_read_regs = pack_addr(5, 3);
    applyStimulus();
    checkOutput("r5_read", port_data(0), 32'hDEAD_BEEF);
    i_enable = 1'b0; i_reg_write = 1'b1; i_write_data = 32'h1; i_read_regs = pack_addr(7, 7);
    applyStimulus();
    checkOutput("disabled_hold", port_data(0), 32'hDEAD_BEEF);
    i_enable = 1'b1; i_reg_write = 1'b0; i_read_regs = pack_addr(5, 5);
    applyStimulus();
    checkOutput("r5_after_disabled_write", port_data(0), 32'hDEAD_BEEF);

    // Bypass on both ports, then bypass on one port with the other reading old r2.
    i_reg_write = 1'b1; i_write_reg = 2; i_write_data = 32'h2222;
    applyStimulus();
    i_write_reg = 9; i_write_data = 32'h1234; i_read_regs = pack_addr(9, 9);
    applyStimulus();
    checkOutput("bypass_p0", port_data(0), 32'h1234);
    checkOutput("bypass_p1", port_data(1), 32'h1234);
    i_write_data = 32'h5678; i_read_regs = pack_addr(9, 2);
    applyStimulus();
    checkOutput("bypass_p0_new", port_data(0), 32'h5678);
    checkOutput("p1_old_r2", port_data(1), 32'h2222);

    // Register 0 write with same-cycle read.
    i_write_reg = 0; i_write_data = 32'hFFFF_FFFF; i_read_regs = pack_addr(0, 0);
    applyStimulus();
    checkOutput("r0_bypass", port_data(0), R0_EXP);

    // Preload rK = K + 0x100.
    for (int k = 0; k < BANK_DEPTH; k++) begin
      i_write_reg = NB_ADDR'(k); i_write_data = 32'h100 + k;
      applyStimulus();
    end
    i_reg_write = 1'b0;

    // Full dump with toggling ready, a blocked write and an ignored start mid-stream.
    dut_beats = 0;
    i_dump_start = 1'b1;
    applyStimulus();
    i_dump_start = 1'b0;
    cyc = 0;
    while (o_dump_busy && cyc < 200) begin
      i_dump_ready = ~cyc[0];
      i_reg_write  = (cyc == 20);
      i_write_reg  = 4; i_write_data = 32'hBAD;
      i_dump_start = (cyc == 30);
      if (o_dump_valid && o_dump_addr == 0)
        checkOutput("dump_beat0", o_dump_data, HW ? 32'h0 : 32'h100);
      applyStimulus();
      cyc++;
    end
    i_reg_write = 1'b0; i_dump_start = 1'b0; i_dump_ready = 1'b0;
    checkOutput("dump_terminates", o_dump_busy, 0);
    checkOutput("dump_beat_count", dut_beats, BANK_DEPTH);
    i_read_regs = pack_addr(4, 31);
    applyStimulus();
    checkOutput("r4_write_blocked", port_data(0), 32'h104);
    checkOutput("r31_preload", port_data(1), 32'h11F);

    // Start and write on the same edge: the dump streams the new value.
    i_dump_start = 1'b1; i_reg_write = 1'b1; i_write_reg = 31; i_write_data = 32'h55;
    applyStimulus();
    i_dump_start = 1'b0; i_reg_write = 1'b0; i_dump_ready = 1'b1;
    cyc = 0;
    while (o_dump_busy && cyc < 100) begin
      if (o_dump_valid && o_dump_addr == 31)
        checkOutput("dump_sees_new_write", o_dump_data, 32'h55);
      applyStimulus();
      cyc++;
    end
    checkOutput("dump2_terminates", o_dump_busy, 0);

    // Reset after ten beats aborts the dump; a new dump restarts at index 0.
    i_dump_start = 1'b1;
    applyStimulus();
    i_dump_start = 1'b0;
    for (int b = 0; b < 10; b++) applyStimulus();
    i_reset = 1'b1;
    applyStimulus();
    i_reset = 1'b0;
    checkOutput("abort_valid", o_dump_valid, 0);
    checkOutput("abort_busy", o_dump_busy, 0);
    i_read_regs = pack_addr(5, 31);
    applyStimulus();
    checkOutput("cleared_r5", port_data(0), 0);
    checkOutput("cleared_r31", port_data(1), 0);
    i_dump_start = 1'b1;
    applyStimulus();
    i_dump_start = 1'b0;
    checkOutput("restart_valid", o_dump_valid, 1);
    checkOutput("restart_addr", o_dump_addr, 0);
    cyc = 0;
    while (o_dump_busy && cyc < 100) begin
      applyStimulus();
      cyc++;
    end
    checkOutput("dump3_terminates", o_dump_busy, 0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      i_reset      = ($urandom_range(0, 99) == 0);
      i_enable     = ($urandom_range(0, 7) != 0);
      i_reg_write  = $urandom_range(0, 1);
      i_write_reg  = NB_ADDR'($urandom_range(0, 31));
      i_write_data = $urandom;
      i_read_regs  = ($urandom_range(0, 3) == 0) ? pack_addr(int'(i_write_reg), int'(i_write_reg))
                                                 : pack_addr($urandom_range(0, 31), $urandom_range(0, 31));
      i_dump_start = ($urandom_range(0, 31) == 0);
      i_dump_ready = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
